bpsk_demodulator: RTL and testbench

Receive-side counterpart to the BPSK modulator stage. It consumes signed carrier samples qualified by Flag and correlates each symbol against a local one-cycle square-wave reference (integrate-and-dump). It makes a hard bit decision per symbol and deserializes NBITS decisions, MSB first, into a parallel word for the downstream decoder. Symbol and word alignment are established by a Sync strobe from the framing logic.

---
 rtl/bpsk_demodulator.sv | 125 ++++++++++++
 tb/tb_bpsk_demodulator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// BPSK integrate-and-dump demodulator: correlates each SPS-sample symbol against a
// one-cycle square-wave reference, slices a hard bit, and packs NBITS bits MSB-first.
module bpsk_demodulator #(
    parameter int WIDTH = 7,
    parameter int SPS   = 4,
    parameter int NBITS = 7
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    Flag,
    input  logic                    Sync,
    output logic                    Bit,
    output logic                    BitValid,
    output logic [NBITS-1:0]        out,
    output logic                    Valid
);
    localparam int ACCW = WIDTH + $clog2(SPS) + 1;
    localparam int CW   = $clog2(SPS);
    localparam int BW   = $clog2(NBITS);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t                  state_q, state_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [CW-1:0]           sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [NBITS-2:0]        shift_q, shift_d;
    logic                    bit_q, bit_d;
    logic                    bit_valid_q, bit_valid_d;
    logic [NBITS-1:0]        out_q, out_d;
    logic                    valid_q, valid_d;

    // Sync clears the symbol/word context before the same-edge sample is processed.
    logic signed [ACCW-1:0]  acc_eff;
    logic [CW-1:0]           cnt_eff;
    logic [BW-1:0]           bcnt_eff;
    logic [NBITS-2:0]        shift_eff;
    logic signed [ACCW-1:0]  in_ext;
    logic signed [ACCW-1:0]  sum;
    logic                    dec;
    logic [NBITS-1:0]        word;

    always_comb begin
        acc_eff   = Sync ? '0 : acc_q;
        cnt_eff   = Sync ? '0 : sample_cnt_q;
        bcnt_eff  = Sync ? '0 : bit_cnt_q;
        shift_eff = Sync ? '0 : shift_q;
        in_ext    = {{(ACCW-WIDTH){in[WIDTH-1]}}, in};
        // Second half of the symbol has the reference at -1.
        sum       = (cnt_eff >= CW'(SPS/2)) ? (acc_eff - in_ext) : (acc_eff + in_ext);
        dec       = !sum[ACCW-1] && (sum != '0);
        word      = {shift_eff, dec};
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        bit_valid_d  = 1'b0;
        out_d        = out_q;
        valid_d      = 1'b0;

        if (Sync) begin
            state_d      = TRACK;
            acc_d        = '0;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
            shift_d      = '0;
        end

        if (Flag && (Sync || state_q == TRACK)) begin
            if (cnt_eff != CW'(SPS-1)) begin
                acc_d        = sum;
                sample_cnt_d = cnt_eff + 1'b1;
            end else begin
                acc_d        = '0;
                sample_cnt_d = '0;
                bit_d        = dec;
                bit_valid_d  = 1'b1;
                if (bcnt_eff != BW'(NBITS-1)) begin
                    shift_d   = word[NBITS-2:0];
                    bit_cnt_d = bcnt_eff + 1'b1;
                end else begin
                    out_d     = word;
                    valid_d   = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            bit_q        <= 1'b0;
            bit_valid_q  <= 1'b0;
            out_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            bit_valid_q  <= bit_valid_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
        end
    end

    assign Bit      = bit_q;
    assign BitValid = bit_valid_q;
    assign out      = out_q;
    assign Valid    = valid_q;
endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench for bpsk_demodulator: expected bits/words are queued as stimulus is
// driven and popped whenever the DUT pulses BitValid/Valid.
module tb_bpsk_demodulator;
    localparam int WIDTH = 7;
    localparam int SPS   = 4;
    localparam int NBITS = 7;

    logic                    CLK = 1'b0;
    logic                    RSTn = 1'b0;
    logic signed [WIDTH-1:0] in_s = '0;
    logic                    Flag = 1'b0;
    logic                    Sync = 1'b0;
    logic                    Bit;
    logic                    BitValid;
    logic [NBITS-1:0]        out;
    logic                    Valid;

    int               n_vec = 0;
    int               n_err = 0;
    bit               exp_bits[$];
    logic [NBITS-1:0] exp_words[$];

    bpsk_demodulator #(.WIDTH(WIDTH), .SPS(SPS), .NBITS(NBITS)) dut (
        .CLK(CLK), .RSTn(RSTn), .in(in_s), .Flag(Flag), .Sync(Sync),
        .Bit(Bit), .BitValid(BitValid), .out(out), .Valid(Valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one edge, then score any output pulse against the queues.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (BitValid === 1'b1) begin
            if (exp_bits.size() == 0) chk("unexpected_bitvalid", BitValid, 0);
            else                      chk("bit", Bit, exp_bits.pop_front());
        end
        if (Valid === 1'b1) begin
            if (exp_words.size() == 0) chk("unexpected_valid", Valid, 0);
            else begin
                chk("word", out, exp_words.pop_front());
                chk("valid_with_bitvalid", BitValid, 1);
            end
        end
    endtask

    task automatic drive(input int s, input logic f, input logic sy);
        in_s = WIDTH'(s);
        Flag = f;
        Sync = sy;
        tick();
        Sync = 1'b0;
        Flag = 1'b0;
    endtask

    function automatic bit decide(input int a, input int b, input int c, input int e);
        return (a + b - c - e) > 0;
    endfunction

    task automatic send_sym(input int a, input int b, input int c, input int e,
                            input bit sy, input bit gap);
        int s[4];
        s = '{a, b, c, e};
        for (int k = 0; k < SPS; k++) begin
            if (k == SPS-1) exp_bits.push_back(decide(a, b, c, e));
            drive(s[k], 1'b1, sy && (k == 0));
            if (gap) drive(-64, 1'b0, 1'b0);
        end
    endtask

    task automatic send_bit(input bit b, input bit sy, input bit gap, input int amp);
        if (b) send_sym(amp, amp, -amp, -amp, sy, gap);
        else   send_sym(-amp, -amp, amp, amp, sy, gap);
    endtask

    task automatic send_word(input logic [NBITS-1:0] w, input bit gap);
        exp_words.push_back(w);
        for (int i = NBITS-1; i >= 0; i--)
            send_bit(w[i], i == NBITS-1, gap, 10 + 3*i);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_bit", Bit, 0);
        chk("rst_bitvalid", BitValid, 0);
        chk("rst_out", out, 0);
        chk("rst_valid", Valid, 0);
        RSTn = 1'b1;

        // IDLE ignores samples until Sync
        for (int i = 0; i < 8; i++) drive(20, 1'b1, 1'b0);
        chk("idle_bitvalid", BitValid, 0);

        // Test 1
        send_sym(20, 20, -20, -20, 1'b1, 1'b0);
        chk("t1_bitvalid", BitValid, 1);
        chk("t1_bit", Bit, 1);
        chk("t1_valid", Valid, 0);
        drive(0, 1'b0, 1'b0);
        chk("t1_bitvalid_pulse", BitValid, 0);
        chk("t1_bit_hold", Bit, 1);

        // Test 2
        send_sym(-20, -20, 20, 20, 1'b0, 1'b0);
        chk("t2_bit_neg", Bit, 0);
        send_sym(20, 20, -20, -20, 1'b0, 1'b0);
        send_sym(5, 5, 5, 5, 1'b0, 1'b0);
        chk("t2_zero_bitvalid", BitValid, 1);
        chk("t2_zero_bit", Bit, 0);

        // Test 3: continuous stream
        send_word(7'b1011001, 1'b0);
        chk("t3_valid", Valid, 1);
        chk("t3_out", out, 7'b1011001);
        drive(0, 1'b0, 1'b0);
        chk("t3_valid_pulse", Valid, 0);
        chk("t3_out_hold", out, 7'b1011001);

        // Test 4: alternate-cycle Flag with junk gap samples
        send_word(7'b1011001, 1'b1);
        chk("t4_valid_after_gap", Valid, 0);
        chk("t4_out", out, 7'b1011001);

        // Test 5: extremes
        send_sym(63, 63, -64, -64, 1'b1, 1'b0);
        chk("t5_pos_extreme", Bit, 1);
        send_sym(-64, -64, 63, 63, 1'b0, 1'b0);
        chk("t5_neg_extreme", Bit, 0);

        // Test 6a: Sync mid-word discards partial word
        send_bit(1'b1, 1'b1, 1'b0, 20);
        send_bit(1'b1, 1'b0, 1'b0, 20);
        send_bit(1'b1, 1'b0, 1'b0, 20);
        drive(20, 1'b1, 1'b0);
        send_word(7'b0111110, 1'b0);
        chk("t6_valid", Valid, 1);
        chk("t6_out", out, 7'b0111110);

        // Test 6b: reset mid-symbol/mid-word
        send_bit(1'b1, 1'b1, 1'b0, 20);
        send_bit(1'b0, 1'b0, 1'b0, 20);
        send_bit(1'b1, 1'b0, 1'b0, 20);
        drive(20, 1'b1, 1'b0);
        drive(20, 1'b1, 1'b0);
        RSTn = 1'b0;
        #1;
        chk("t6_rst_bit", Bit, 0);
        chk("t6_rst_bitvalid", BitValid, 0);
        chk("t6_rst_out", out, 0);
        chk("t6_rst_valid", Valid, 0);
        drive(20, 1'b1, 1'b0);
        drive(20, 1'b1, 1'b0);
        RSTn = 1'b1;
        for (int i = 0; i < 8; i++) drive(20, 1'b1, 1'b0);
        chk("t6_idle_bitvalid", BitValid, 0);
        chk("t6_idle_out", out, 0);
        send_word(7'b1100101, 1'b0);
        chk("t6_recover_valid", Valid, 1);
        chk("t6_recover_out", out, 7'b1100101);
        drive(0, 1'b0, 1'b0);

        chk("bits_drained", exp_bits.size(), 0);
        chk("words_drained", exp_words.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
